seven_seg_mux: RTL and testbench

SEVEN_SEG_MUX -- requirements
Module: seven_seg_mux

---
 rtl/seven_seg_pkg.sv | 30 +++
 rtl/hex_to_seg.sv | 14 +
 rtl/seven_seg_mux.sv | 233 +++++++++++++++++++++++
 tb/tb_seven_seg_mux.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment driver: scan FSM
// states, segment bit positions and the hex-to-segment lookup table.
// Segment vectors are active high, bit 6 = A down to bit 0 = G.
package seven_seg_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  // Bit positions of the individual segments inside a 7-bit segment vector.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Indexed by nibble value; leftmost entry is nibble F, rightmost is 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to seven-segment decoder (active-high, A..G).
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Pure table lookup; glyphs 0-9, A, b, C, d, E, F.
  always_comb begin
    seg = hex_seg(nib);
  end

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed seven-segment display driver.
// Each digit gets a slot of SCAN_DIV cycles: SCAN_DIV-DEAD cycles driven
// (SHOW) followed by DEAD blank cycles (BLANK) to suppress ghosting.
// Display data is latched on load and handed to the scan path only at slot
// boundaries, so a digit never changes glyph in the middle of its slot.
// Optional build macro SEVEN_SEG_LZB_EN enables leading-zero blanking.
// rst is asynchronous and active low.
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEAD     = 2,
  parameter int BLINK_W  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bin_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [BLINK_W-1:0]    blink_rate,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     en
);

  localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SHOW_LEN = SCAN_DIV - DEAD;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_LEN - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((DEAD > 0) ? DEAD - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  // Display registers written by load
  logic [4*DIGITS-1:0] disp_bin_reg;
  logic [DIGITS-1:0]   disp_dp_reg;
  logic [DIGITS-1:0]   disp_mask_reg;

  // Data seen by a slot starting on this edge (load bypasses the registers)
  logic [4*DIGITS-1:0] src_bin;
  logic [DIGITS-1:0]   src_dp;
  logic [DIGITS-1:0]   src_mask;
  logic [3:0]          src_nib [DIGITS];
  logic [DIGITS-1:0]   lz_blank;

  // Scan FSM
  scan_state_t         state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [IDX_W-1:0]    idx_reg, idx_next, idx_inc;
  logic                slot_start;

  // Per-slot snapshot of the driven digit
  logic [3:0]          cur_nib_reg;
  logic                cur_dp_reg;
  logic                cur_mask_reg;
  logic                cur_lzb_reg;

  // Blink generator
  logic [BLINK_W-1:0]  blink_cnt_reg;
  logic                phase_on_reg;

  // Output stage
  logic [6:0]          dec_seg;
  logic                show_on;
  logic                blink_off;
  logic [6:0]          seg_reg, seg_next;
  logic                dp_reg, dp_next;
  logic [DIGITS-1:0]   en_reg, en_next;

  // Latch new display contents on load; reset clears them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_bin_reg  <= '0;
      disp_dp_reg   <= '0;
      disp_mask_reg <= '0;
    end else if (load) begin
      disp_bin_reg  <= bin_in;
      disp_dp_reg   <= dp_in;
      disp_mask_reg <= blink_mask;
    end
  end

  // A load on a boundary edge must feed the slot that starts on that edge
  always_comb begin
    src_bin  = load ? bin_in     : disp_bin_reg;
    src_dp   = load ? dp_in      : disp_dp_reg;
    src_mask = load ? blink_mask : disp_mask_reg;
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign src_nib[gi] = src_bin[4*gi +: 4];
  end

`ifdef SEVEN_SEG_LZB_EN
  // Digit i is a leading zero when it and every digit above it is zero;
  // digit 0 is never blanked so a zero value still shows "0"
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above && (src_nib[i] == 4'h0);
      lz_blank[i] = zero_above;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Scan FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= SHOW;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
    end
  end

  // Next digit index with wrap
  always_comb begin
    idx_inc = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
  end

  // Scan FSM next state: SHOW for SHOW_LEN cycles, then BLANK for DEAD cycles
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    idx_next   = idx_reg;
    slot_start = 1'b0;
    case (state_reg)
      SHOW: begin
        if (cnt_reg == SHOW_LAST) begin
          cnt_next = '0;
          if (DEAD == 0) begin
            idx_next   = idx_inc;
            slot_start = 1'b1;
          end else begin
            state_next = BLANK;
          end
        end
      end
      BLANK: begin
        if (cnt_reg == BLANK_LAST) begin
          cnt_next   = '0;
          state_next = SHOW;
          idx_next   = idx_inc;
          slot_start = 1'b1;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = SHOW;
      end
    endcase
  end

  // Snapshot the incoming digit's data at the start of its slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_nib_reg  <= '0;
      cur_dp_reg   <= 1'b0;
      cur_mask_reg <= 1'b0;
      cur_lzb_reg  <= 1'b0;
    end else if (slot_start) begin
      cur_nib_reg  <= src_nib[idx_next];
      cur_dp_reg   <= src_dp[idx_next];
      cur_mask_reg <= src_mask[idx_next];
      cur_lzb_reg  <= lz_blank[idx_next];
    end
  end

  // Blink half-period timer; a rate of zero parks the phase at "on".
  // The >= compare lets a lowered rate take effect on the next compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_reg <= '0;
      phase_on_reg  <= 1'b1;
    end else if (blink_rate == '0) begin
      blink_cnt_reg <= '0;
      phase_on_reg  <= 1'b1;
    end else if (blink_cnt_reg >= blink_rate) begin
      blink_cnt_reg <= '0;
      phase_on_reg  <= ~phase_on_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + 1'b1;
    end
  end

  hex_to_seg u_hex_to_seg (
    .nib (cur_nib_reg),
    .seg (dec_seg)
  );

  // Output values for the current scan position
  always_comb begin
    show_on   = (state_reg == SHOW);
    blink_off = cur_mask_reg && !phase_on_reg;
    en_next   = '0;
    seg_next  = '0;
    dp_next   = 1'b0;
    if (show_on) begin
      en_next[idx_reg] = 1'b1;
      if (!blink_off) begin
        seg_next = cur_lzb_reg ? 7'h00 : dec_seg;
        dp_next  = cur_dp_reg;
      end
    end
  end

  // Registered outputs so seg/dp/en only change on a rising clock edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_reg <= '0;
      dp_reg  <= 1'b0;
      en_reg  <= '0;
    end else begin
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
      en_reg  <= en_next;
    end
  end

  assign seg = seg_reg;
  assign dp  = dp_reg;
  assign en  = en_reg;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Self-checking bench for seven_seg_mux (DIGITS=4, SCAN_DIV=8, DEAD=2).
// Every edge is compared against a reference model that derives the
// expected outputs from the scan position, the data captured at the
// start of each slot, and the blink phase formula.
module tb_seven_seg_mux;

  localparam int NDIG  = 4;
  localparam int SCAN  = 8;
  localparam int DEADC = 2;
  localparam int HMAX  = 4096;

  typedef struct packed {
    logic [15:0] bin;
    logic [3:0]  dpv;
    logic [3:0]  mask;
  } disp_t;

  typedef struct packed {
    logic [15:0] bin;
    logic [3:0]  dpv;
    logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] bin_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_mask = '0;
  logic [23:0] blink_rate = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  en;

  int    n_checks = 0;
  int    n_pass = 0;
  int    k = 0;          // edges since reset release
  int    cur_rate = 0;
  disp_t mdisp;
  disp_t hist [HMAX];
  logic [6:0] segt [16];
  vec_t  vecs [6];

  seven_seg_mux #(
    .DIGITS   (NDIG),
    .SCAN_DIV (SCAN),
    .DEAD     (DEADC),
    .BLINK_W  (24)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .bin_in     (bin_in),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .blink_rate (blink_rate),
    .seg        (seg),
    .dp         (dp),
    .en         (en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Expected outputs after edge kk (kk = 0 means held in reset)
  function automatic void model_out(input int kk, output logic [3:0] e_en,
                                    output logic [6:0] e_seg, output logic e_dp);
    int p, off, dig;
    disp_t d;
    logic [15:0] upper;
    logic [3:0] nib;
    bit phase_on, bb, lz;
    e_en = '0; e_seg = '0; e_dp = 1'b0;
    if (kk == 0) return;
    p   = kk - 1;
    off = p % SCAN;
    dig = (p / SCAN) % NDIG;
    if (off >= SCAN - DEADC) return;
    d        = hist[p - off];
    upper    = d.bin >> (4 * dig);
    nib      = upper[3:0];
    phase_on = (cur_rate == 0) || (((p / (cur_rate + 1)) % 2) == 0);
    bb       = d.mask[dig] && !phase_on;
    lz       = 1'b0;
`ifdef SEVEN_SEG_LZB_EN
    lz = (dig > 0) && (upper == 16'h0000);
`endif
    e_en  = 4'(1 << dig);
    e_seg = (bb || lz) ? 7'h00 : segt[nib];
    e_dp  = !bb && d.dpv[dig];
  endfunction

  // One clock edge: advance the model, then compare all outputs
  task automatic tick();
    logic [3:0] e_en;
    logic [6:0] e_seg;
    logic       e_dp;
    @(posedge clk);
    if (rst) begin
      k++;
      if (k >= HMAX) begin
        $display("FAIL history_bound: got %0d expected below %0d", k, HMAX);
        $fatal(1, "history overflow");
      end
      if (load) mdisp = {bin_in, dp_in, blink_mask};
      hist[k] = mdisp;
    end
    #1;
    model_out(k, e_en, e_seg, e_dp);
    check($sformatf("scan k=%0d en/seg/dp", k), 32'({en, seg, dp}), 32'({e_en, e_seg, e_dp}));
  endtask

  task automatic do_reset(input int cycles);
    rst   = 1'b0;
    k     = 0;
    mdisp = '0;
    hist[0] = '0;
    #1;
    check("async_reset_outputs_zero", 32'({en, seg, dp}), 32'h0);
    repeat (cycles) tick();
    rst = 1'b1;
  endtask

  task automatic wait_en(input logic [3:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (en == target) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    logic [7:0] obs_seg [4];
    logic [3:0] obs_dp;
    logic [3:0] exp_en_seq [9];
    int saw47, saw00, bad1;

    segt = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    exp_en_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                   4'b0000, 4'b0000, 4'b0010};
    vecs[0] = '{bin: 16'h1A2F, dpv: 4'b0100, segs: {7'h30, 7'h77, 7'h6D, 7'h47}};
`ifdef SEVEN_SEG_LZB_EN
    vecs[1] = '{bin: 16'h0050, dpv: 4'b0000, segs: {7'h00, 7'h00, 7'h5B, 7'h7E}};
    vecs[5] = '{bin: 16'h0000, dpv: 4'b1000, segs: {7'h00, 7'h00, 7'h00, 7'h7E}};
`else
    vecs[1] = '{bin: 16'h0050, dpv: 4'b0000, segs: {7'h7E, 7'h7E, 7'h5B, 7'h7E}};
    vecs[5] = '{bin: 16'h0000, dpv: 4'b1000, segs: {7'h7E, 7'h7E, 7'h7E, 7'h7E}};
`endif
    vecs[2] = '{bin: 16'h8888, dpv: 4'b1111, segs: {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
    vecs[3] = '{bin: 16'hC3D6, dpv: 4'b1010, segs: {7'h4E, 7'h79, 7'h3D, 7'h5F}};
    vecs[4] = '{bin: 16'h9E4B, dpv: 4'b0001, segs: {7'h7B, 7'h4F, 7'h33, 7'h1F}};

    // Reset for 3 cycles, then the first slot timing
    #2;
    do_reset(3);
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("startup_en[%0d]", i), 32'(en), 32'(exp_en_seq[i]));
    end
    $display("seq startup: en timing after reset release checked");

    // Table-driven display contents
    for (int v = 0; v < 6; v++) begin
      bin_in = vecs[v].bin; dp_in = vecs[v].dpv; blink_mask = '0; load = 1'b1;
      tick();
      load = 1'b0;
      repeat (40) tick();
      for (int d = 0; d < 4; d++) obs_seg[d] = 8'hFF;
      obs_dp = '0;
      repeat (32) begin
        tick();
        for (int d = 0; d < 4; d++)
          if (en == 4'(1 << d)) begin
            obs_seg[d] = {1'b0, seg};
            obs_dp[d]  = dp;
          end
      end
      for (int d = 0; d < 4; d++)
        check($sformatf("vec%0d_seg_digit%0d", v, d), 32'(obs_seg[d]), 32'((vecs[v].segs >> (7 * d)) & 28'h7F));
      check($sformatf("vec%0d_dp", v), 32'(obs_dp), 32'(vecs[v].dpv));
      $display("vec %0d: bin=%h dp_in=%b seg d3..d0=%h %h %h %h", v, vecs[v].bin, vecs[v].dpv,
               obs_seg[3], obs_seg[2], obs_seg[1], obs_seg[0]);
    end

    // Reset asserted in the middle of digit 2's slot
    bin_in = 16'h1A2F; dp_in = 4'b0100; load = 1'b1;
    tick();
    load = 1'b0;
    wait_en(4'b0100, 80, ok);
    check("wait_digit2", 32'(ok), 32'd1);
    tick();
    do_reset(2);
    tick();
    check("rst_restart_en", 32'(en), 32'h1);
    check("rst_cleared_seg", 32'(seg), 32'h7E);
    bin_in = 16'h0000; dp_in = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (40) tick();
    $display("seq midslot reset: restart at digit 0 with cleared data");

    // Blink on digit 0 with a 32-cycle half period
    blink_rate = 24'd31; cur_rate = 31;
    do_reset(2);
    bin_in = 16'h1A2F; dp_in = 4'b0000; blink_mask = 4'b0001; load = 1'b1;
    tick();
    load = 1'b0;
    saw47 = 0; saw00 = 0; bad1 = 0;
    repeat (260) begin
      tick();
      if (en == 4'b0001 && seg == 7'h47) saw47++;
      if (en == 4'b0001 && seg == 7'h00) saw00++;
      if (en == 4'b0010 && seg != 7'h6D) bad1++;
    end
    check("blink_digit0_on_seen", 32'(saw47 > 0), 32'd1);
    check("blink_digit0_off_seen", 32'(saw00 > 0), 32'd1);
    check("blink_digit1_steady", 32'(bad1), 32'd0);
    $display("seq blink: digit0 on=%0d off=%0d cycles", saw47, saw00);

    // Randomized epochs against the reference model
    for (int e = 0; e < 4; e++) begin
      cur_rate   = (e == 0) ? 0 : int'($urandom_range(3, 40));
      blink_rate = 24'(cur_rate);
      load = 1'b0;
      do_reset(2);
      repeat (500) begin
        load       = ($urandom_range(0, 7) == 0);
        bin_in     = 16'($urandom);
        dp_in      = 4'($urandom);
        blink_mask = 4'($urandom);
        tick();
      end
      load = 1'b0;
      $display("random epoch %0d: blink_rate=%0d, %0d checks so far", e, cur_rate, n_checks);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
